// File: rtl/cpu_v2_pkg.sv
// Shared types and constants for the v2 multicycle core: opcode and state
// encodings, the flag bundle, and the bit positions of the instruction fields.
package cpu_v2_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_SHL   = 4'h5,
    OP_SHR   = 4'h6,
    OP_CMP   = 4'h7,
    OP_BEQ   = 4'h8,
    OP_BNE   = 4'h9,
    OP_JMP   = 4'hA,
    OP_MUL   = 4'hB,
    OP_HALT  = 4'hC,
    OP_STORE = 4'hD,
    OP_LOAD  = 4'hE,
    OP_LDI   = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic n;
    logic c;
    logic z;
  } flags_t;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

endpackage

// File: rtl/regfile_v2.sv
// Register file for the v2 core: two combinational read ports, one synchronous
// write port and a debug read port. Indices at or above NREGS read as zero and
// writes to them are dropped. All registers clear asynchronously on rst_n.
module regfile_v2 #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [3:0]        rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NREGS];

  // Single write port; an out-of-range address matches no entry and is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_addr == 4'(i)) regs[i] <= wr_data;
      end
    end
  end

  // Read ports as explicit muxes so unmatched indices fall back to zero
  always_comb begin
    ra_data  = '0;
    rb_data  = '0;
    dbg_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (ra_addr == 4'(i))  ra_data  = regs[i];
      if (rb_addr == 4'(i))  rb_data  = regs[i];
      if (dbg_addr == 4'(i)) dbg_data = regs[i];
    end
  end

endmodule

// File: rtl/cpu_core_v2.sv
// Multicycle v2 core: FETCH -> EXEC (-> MEM) -> FETCH, with HALT as a sink
// left only by reset. Instruction and data memories sit behind req/ack.
// Optional feature: define CPU_MUL_EN to make opcode B a multiply; without it
// opcode B is illegal and stops the core with fault raised.
module cpu_core_v2
  import cpu_v2_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NREGS   = 16,
  parameter int PC_W    = 8,
  parameter int DADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [15:0]        imem_data,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic [3:0]         dbg_addr,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [PC_W-1:0]    pc,
  output logic [2:0]         flags,
  output logic               halted,
  output logic               fault
);

  state_t            state, state_next;
  logic [15:0]       ir;
  logic              ir_load;
  flags_t            flg, flags_next;
  logic [PC_W-1:0]   pc_next;
  logic              fault_next;
  opcode_t           op;
  logic [3:0]        rd, rs1, rs2;
  logic [7:0]        imm;
  logic [DATA_W-1:0] a, b;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic [DATA_W:0]   sum;
  logic [31:0]       shamt;

  assign op  = opcode_t'(ir[OP_HI:OP_LO]);
  assign rd  = ir[RD_HI:RD_LO];
  assign rs1 = ir[RS1_HI:RS1_LO];
  assign rs2 = ir[RS2_HI:RS2_LO];
  assign imm = ir[IMM_HI:IMM_LO];

  regfile_v2 #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_addr  (rs1),
    .ra_data  (a),
    .rb_addr  (rs2),
    .rb_data  (b),
    .wr_en    (wr_en),
    .wr_addr  (rd),
    .wr_data  (wr_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Operands come straight from the instruction register and register file,
  // which both stay put during MEM, so the data request is held stable.
  assign imem_addr  = pc;
  assign dmem_we    = (op == OP_STORE);
  assign dmem_addr  = DADDR_W'(a);
  assign dmem_wdata = b;
  assign flags      = flg;
  assign halted     = (state == HALT);

  // ALU: result plus carry; subtract uses a + ~b + 1 so carry means no borrow
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    sum     = '0;
    shamt   = 32'(b) % 32'(DATA_W);
    case (op)
      OP_ADD: begin
        sum     = {1'b0, a} + {1'b0, b};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OP_SUB, OP_CMP: begin
        sum     = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: alu_res = a << shamt;
      OP_SHR: alu_res = a >> shamt;
`ifdef CPU_MUL_EN
      OP_MUL: alu_res = a * b;
`endif
      default: alu_res = '0;
    endcase
  end

  // State, pc, flags, fault and instruction register updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
      flg   <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      flg   <= flags_next;
      fault <= fault_next;
      if (ir_load) ir <= imem_data;
    end
  end

  // Next-state decode, handshake requests and register write control
  always_comb begin
    state_next = state;
    pc_next    = pc;
    flags_next = flg;
    fault_next = fault;
    ir_load    = 1'b0;
    wr_en      = 1'b0;
    wr_data    = alu_res;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    case (state)
      FETCH: begin
        imem_req = rst_n;
        if (imem_ack) begin
          ir_load    = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = FETCH;
        pc_next    = pc + PC_W'(1);
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
            wr_en      = 1'b1;
            flags_next = '{n: alu_res[DATA_W-1], c: alu_c, z: (alu_res == '0)};
          end
          OP_CMP: flags_next = '{n: alu_res[DATA_W-1], c: alu_c, z: (alu_res == '0)};
          OP_BEQ: if (flg.z) pc_next = PC_W'(imm);
          OP_BNE: if (!flg.z) pc_next = PC_W'(imm);
          OP_JMP: pc_next = PC_W'(imm);
          OP_LDI: begin
            wr_en   = 1'b1;
            wr_data = DATA_W'(imm);
          end
          OP_HALT: begin
            state_next = HALT;
            pc_next    = pc;
          end
          OP_STORE, OP_LOAD: begin
            state_next = MEM;
            pc_next    = pc;
          end
`ifdef CPU_MUL_EN
          OP_MUL: begin
            wr_en      = 1'b1;
            flags_next = '{n: alu_res[DATA_W-1], c: 1'b0, z: (alu_res == '0)};
          end
`else
          OP_MUL: begin
            fault_next = 1'b1;
            state_next = HALT;
            pc_next    = pc;
          end
`endif
          default: begin
            fault_next = 1'b1;
            state_next = HALT;
            pc_next    = pc;
          end
        endcase
      end
      MEM: begin
        dmem_req = rst_n;
        if (dmem_ack) begin
          wr_en      = !dmem_we;
          wr_data    = dmem_rdata;
          pc_next    = pc + PC_W'(1);
          state_next = FETCH;
        end
      end
      HALT: state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

endmodule
